// File: rtl/logic_pkg.sv
// Shared types for the streaming bitwise reduction unit: the operation
// encoding seen on the op port and the controller state encoding.
package logic_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/bitwise_op.sv
// Combinational fold step: combines the running accumulator with a new word.
// NAND folds as AND; the final inversion happens once, at the output.
module bitwise_op
    import logic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Select the bitwise function; AND is the default so NAND maps onto it.
    always_comb begin
        y = a & b;
        case (op)
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = a & b;
        endcase
    end

endmodule

// File: rtl/logic_accum.sv
// Streaming bitwise reduction unit. Folds a burst of words through
// AND/OR/XOR/NAND and presents one registered result per burst.
module logic_accum
    import logic_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         op,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [COUNT_W-1:0] out_count,
    output logic               busy
);

    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   fold_res;
    logic               beat;

    // The operation applied to every beat after the first comes from the
    // latched op, so op changes mid-burst have no effect.
    bitwise_op #(
        .WIDTH(WIDTH)
    ) u_bitwise_op (
        .op(op_q),
        .a (acc_q),
        .b (in_data),
        .y (fold_res)
    );

    assign beat = in_valid && in_ready;

    // Next-state and register-update logic for the burst controller.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (beat) begin
                    op_d    = op_e'(op);
                    acc_d   = in_data;
                    cnt_d   = CNT_ONE;
                    state_d = in_last ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (beat) begin
                    acc_d = fold_res;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    if (in_last) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial burst.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_AND;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode registered state only, so nothing on the input side
    // reaches them combinationally. Result fields read zero outside HOLD.
    assign in_ready  = (state_q != S_HOLD);
    assign out_valid = (state_q == S_HOLD);
    assign busy      = (state_q != S_IDLE);
    assign out_data  = (state_q != S_HOLD) ? '0 :
                       (op_q == OP_NAND)   ? ~acc_q : acc_q;
    assign out_count = (state_q == S_HOLD) ? cnt_q : '0;

endmodule

// File: tb/tb_logic_accum.sv
// Directed self-checking bench for logic_accum. Two instances share the
// stimulus: the default COUNT_W=8 and a COUNT_W=2 one for saturation.
module tb_logic_accum;

    logic        clk;
    logic        reset_n;
    logic [1:0]  op;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [7:0]  out_count;
    logic        busy;

    logic        in_ready_s;
    logic        out_valid_s;
    logic [15:0] out_data_s;
    logic [1:0]  out_count_s;
    logic        busy_s;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  count;
        logic [1:0]  count_sat;
    } exp_t;

    exp_t scoreboard[$];

    int compared   = 0;
    int mismatched = 0;

    logic_accum #(.WIDTH(16), .COUNT_W(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .op       (op),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_count(out_count),
        .busy     (busy)
    );

    logic_accum #(.WIDTH(16), .COUNT_W(2)) dut_sat (
        .clk      (clk),
        .reset_n  (reset_n),
        .op       (op),
        .in_valid (in_valid),
        .in_ready (in_ready_s),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid_s),
        .out_ready(out_ready),
        .out_data (out_data_s),
        .out_count(out_count_s),
        .busy     (busy_s)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison point: counts it, and reports tag/observed/expected on failure.
    task automatic expectEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; all sampling and driving happens 1 unit after the edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for a single cycle; the unit is ready whenever this is called.
    task automatic applyStimulus(input logic [1:0] op_v, input logic [15:0] data_v, input logic last_v);
        op       = op_v;
        in_data  = data_v;
        in_last  = last_v;
        in_valid = 1'b1;
        stepCycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Checks that the result is already visible one cycle after the last beat,
    // holds it for hold_cycles under back-pressure, then completes the handshake.
    task automatic checkOutput(input string tag, input int hold_cycles);
        exp_t e;
        if (scoreboard.size() == 0) begin
            expectEq({tag, "_sb_empty"}, 32'(scoreboard.size()), 32'd1);
            return;
        end
        e = scoreboard.pop_front();
        for (int i = 0; i <= hold_cycles; i++) begin
            expectEq({tag, "_out_valid"},   32'(out_valid),   32'd1);
            expectEq({tag, "_out_data"},    32'(out_data),    32'(e.data));
            expectEq({tag, "_out_count"},   32'(out_count),   32'(e.count));
            expectEq({tag, "_in_ready"},    32'(in_ready),    32'd0);
            expectEq({tag, "_busy"},        32'(busy),        32'd1);
            expectEq({tag, "_sat_valid"},   32'(out_valid_s), 32'd1);
            expectEq({tag, "_sat_data"},    32'(out_data_s),  32'(e.data));
            expectEq({tag, "_sat_count"},   32'(out_count_s), 32'(e.count_sat));
            if (i < hold_cycles) begin
                stepCycle();
            end
        end
        out_ready = 1'b1;
        stepCycle();
        out_ready = 1'b0;
        expectEq({tag, "_post_valid"},    32'(out_valid),   32'd0);
        expectEq({tag, "_post_busy"},     32'(busy),        32'd0);
        expectEq({tag, "_post_in_ready"}, 32'(in_ready),    32'd1);
        expectEq({tag, "_post_data"},     32'(out_data),    32'd0);
        expectEq({tag, "_post_sat_busy"}, 32'(busy_s),      32'd0);
    endtask

    // Linear sequence of directed scenarios.
    initial begin
        reset_n   = 1'b0;
        op        = 2'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset held for two edges, then released.
        stepCycle();
        stepCycle();
        reset_n = 1'b1;
        expectEq("rst_in_ready",  32'(in_ready),  32'd1);
        expectEq("rst_out_valid", 32'(out_valid), 32'd0);
        expectEq("rst_out_data",  32'(out_data),  32'd0);
        expectEq("rst_out_count", 32'(out_count), 32'd0);
        expectEq("rst_busy",      32'(busy),      32'd0);
        stepCycle();
        expectEq("idle_busy",     32'(busy),      32'd0);

        // AND burst of three words.
        applyStimulus(2'd0, 16'hFFF0, 1'b0);
        expectEq("and_mid_busy",     32'(busy),      32'd1);
        expectEq("and_mid_in_ready", 32'(in_ready),  32'd1);
        expectEq("and_mid_valid",    32'(out_valid), 32'd0);
        applyStimulus(2'd0, 16'h0FFF, 1'b0);
        scoreboard.push_back('{16'h0C30, 8'd3, 2'd3});
        applyStimulus(2'd0, 16'h3C3C, 1'b1);
        checkOutput("and3", 0);

        // XOR burst with five cycles of back-pressure.
        applyStimulus(2'd2, 16'h00FF, 1'b0);
        scoreboard.push_back('{16'h0FF0, 8'd2, 2'd2});
        applyStimulus(2'd2, 16'h0F0F, 1'b1);
        checkOutput("xor_bp", 5);

        // NAND single beat.
        scoreboard.push_back('{16'hEDCB, 8'd1, 2'd1});
        applyStimulus(2'd3, 16'h1234, 1'b1);
        checkOutput("nand1", 0);

        // NAND burst whose later beat carries op=OR; the latched NAND must persist.
        applyStimulus(2'd3, 16'h1234, 1'b0);
        scoreboard.push_back('{16'hEDFF, 8'd2, 2'd2});
        applyStimulus(2'd1, 16'hFF00, 1'b1);
        checkOutput("nand_opchg", 0);

        // Idle cycles with in_valid low change nothing.
        stepCycle();
        expectEq("idle_gap_busy", 32'(busy), 32'd0);

        // OR burst aborted by reset after two beats.
        applyStimulus(2'd1, 16'h0100, 1'b0);
        applyStimulus(2'd1, 16'h0010, 1'b0);
        reset_n = 1'b0;
        stepCycle();
        reset_n = 1'b1;
        expectEq("midrst_valid", 32'(out_valid), 32'd0);
        expectEq("midrst_busy",  32'(busy),      32'd0);
        expectEq("midrst_ready", 32'(in_ready),  32'd1);
        stepCycle();
        expectEq("midrst_valid2", 32'(out_valid), 32'd0);
        scoreboard.push_back('{16'h0001, 8'd1, 2'd1});
        applyStimulus(2'd1, 16'h0001, 1'b1);
        checkOutput("post_rst", 0);

        // Six-beat AND burst: 8-bit counter reads 6, 2-bit counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'd0, 16'hFFFF, 1'b0);
        end
        scoreboard.push_back('{16'hFFFF, 8'd6, 2'd3});
        applyStimulus(2'd0, 16'hFFFF, 1'b1);
        checkOutput("sat6", 0);

        expectEq("sb_drained", 32'(scoreboard.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Safety net so the run always ends even if the sequence stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
